mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch vs load/store) with a grant watchdog.
// Define MEM_ARBITER_RR_EN for round-robin ties; otherwise load/store wins ties.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_read,
    input  logic [63:0] if_address,
    output logic [63:0] if_readdata,
    output logic        if_done,
    input  logic        ls_read,
    input  logic        ls_write,
    input  logic [63:0] ls_address,
    input  logic [1:0]  ls_datasize,
    input  logic [63:0] ls_writedata,
    output logic [63:0] ls_readdata,
    output logic        ls_done,
    output logic [63:0] mem_address,
    output logic [1:0]  mem_datasize,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    input  logic [63:0] mem_readdata,
    input  logic        mem_done,
    output logic [1:0]  grant,
    output logic        timeout
);

    typedef enum logic [1:0] {SIdle = 2'b00, SIf = 2'b01, SLs = 2'b10} state_e;

    localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 32'd1);

    state_e      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        if_pend, ls_pend, active, expired, pick_ls;

    assign if_pend = if_read;
    assign ls_pend = ls_read | ls_write;
    // A grant is live only while its owner keeps requesting; a dropped request aborts silently.
    assign active  = ((state_q == SIf) & if_pend) | ((state_q == SLs) & ls_pend);
    assign expired = active & ~mem_done & (wait_q == WaitLast);

`ifdef MEM_ARBITER_RR_EN
    logic last_ls_q, last_ls_d, done_any;

    assign done_any = active & (mem_done | expired);
    assign pick_ls  = ~last_ls_q;

    always_comb begin
        last_ls_d = last_ls_q;
        if (done_any) begin
            last_ls_d = (state_q == SLs);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_ls_q <= 1'b1;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end
`else
    assign pick_ls = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SIdle;
            wait_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SIdle: begin
                if (if_pend && ls_pend) begin
                    state_d = pick_ls ? SLs : SIf;
                end else if (ls_pend) begin
                    state_d = SLs;
                end else if (if_pend) begin
                    state_d = SIf;
                end
            end
            SIf: begin
                if (!active) begin
                    state_d = SIdle;
                end else if (mem_done) begin
                    state_d = ls_pend ? SLs : SIdle;
                end else if (expired) begin
                    state_d = SIdle;
                end
            end
            SLs: begin
                if (!active) begin
                    state_d = SIdle;
                end else if (mem_done) begin
                    state_d = if_pend ? SIf : SIdle;
                end else if (expired) begin
                    state_d = SIdle;
                end
            end
            default: state_d = SIdle;
        endcase
    end

    // Staying in the same grant state implies no mem_done, so the counter simply advances.
    assign wait_d = ((state_q != SIdle) && (state_d == state_q)) ? wait_q + 16'd1 : 16'd0;

    always_comb begin
        grant         = 2'b00;
        timeout       = 1'b0;
        mem_address   = '0;
        mem_datasize  = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = '0;
        if_readdata   = '0;
        if_done       = 1'b0;
        ls_readdata   = '0;
        ls_done       = 1'b0;
        if (reset_n) begin
            grant   = state_q;
            timeout = expired;
            unique case (state_q)
                SIf: begin
                    mem_address  = if_address;
                    mem_datasize = 2'd3;
                    mem_read     = if_read & ~expired;
                    if_done      = active & (mem_done | expired);
                    if_readdata  = expired ? '0 : mem_readdata;
                end
                SLs: begin
                    mem_address   = ls_address;
                    mem_datasize  = ls_datasize;
                    mem_read      = ls_read & ~expired;
                    mem_write     = ls_write & ~expired;
                    mem_writedata = ls_writedata;
                    ls_done       = active & (mem_done | expired);
                    ls_readdata   = expired ? '0 : mem_readdata;
                end
                default: ;
            endcase
        end
    end

endmodule
